// File: rtl/bus_pkg.sv
// bus_pkg: shared grant encodings, FSM state type and select width for the bus arbiter
package bus_pkg;
  localparam int ADDR_SEL_BITS = 2;
  localparam int SEL_CNT_W = $clog2(ADDR_SEL_BITS);
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M1 = 2'b01;
  localparam logic [1:0] GRANT_M2 = 2'b10;
  localparam logic [2:0] SLAVE_NONE = 3'b000;
  localparam logic [2:0] SLAVE_S1 = 3'b011;
  localparam logic [2:0] SLAVE_S2 = 3'b101;
  localparam logic [2:0] SLAVE_S3 = 3'b111;
  typedef enum logic [1:0] {IDLE, ADDR, CONNECT, HOLD} state_t;
endpackage

// File: rtl/addr_deser.sv
// addr_deser: serial slave-select shifter with bit counter and address timeout counter
module addr_deser import bus_pkg::*; #(
  parameter int ADDR_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     valid,
  input  logic                     bit_in,
  output logic [ADDR_SEL_BITS-1:0] sel_nxt,
  output logic                     last_bit,
  output logic                     timeout
);
  localparam int TW = $clog2(ADDR_TIMEOUT + 1);
  logic [ADDR_SEL_BITS-1:0] sel;
  logic [SEL_CNT_W-1:0] bit_cnt;
  logic [TW-1:0] tmo;
  assign sel_nxt = {sel[ADDR_SEL_BITS-2:0], bit_in};
  assign last_bit = valid && bit_cnt == SEL_CNT_W'(ADDR_SEL_BITS - 1);
  assign timeout = !valid && tmo == TW'(ADDR_TIMEOUT - 1);
  // shift qualified bits MSB first, count idle cycles otherwise
  always_ff @(posedge clk)
    if (!rstn || clr) begin
      sel <= '0;
      bit_cnt <= '0;
      tmo <= '0;
    end else if (en) begin
      if (valid) begin
        sel <= sel_nxt;
        bit_cnt <= bit_cnt + 1'b1;
      end else
        tmo <= tmo + 1'b1;
    end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin bus arbiter with serial slave-select decode
module bus_arbiter import bus_pkg::*; #(
  parameter int ADDR_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       m1_request,
  input  logic       m2_request,
  input  logic       m1_master_valid,
  input  logic       m2_master_valid,
  input  logic       m1_tx_address,
  input  logic       m2_tx_address,
  output logic [1:0] bus_grant,
  output logic [2:0] slave_grant,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic       decode_error
);
  state_t state;
  logic last_m2;
  logic pick_m2;
  logic req;
  logic valid;
  logic addr;
  logic [ADDR_SEL_BITS-1:0] sel_nxt;
  logic last_bit;
  logic timeout;
  assign m1_grant = bus_grant[0];
  assign m2_grant = bus_grant[1];
  assign pick_m2 = m2_request && (!m1_request || !last_m2);
  assign req = bus_grant == GRANT_M1 ? m1_request : m2_request;
  assign valid = bus_grant == GRANT_M1 ? m1_master_valid : bus_grant == GRANT_M2 ? m2_master_valid : 1'b0;
  assign addr = bus_grant == GRANT_M1 ? m1_tx_address : bus_grant == GRANT_M2 ? m2_tx_address : 1'b0;
  addr_deser #(.ADDR_TIMEOUT(ADDR_TIMEOUT)) u_deser (
    .clk(clk),
    .rstn(rstn),
    .clr(state == IDLE),
    .en(state == ADDR),
    .valid(valid),
    .bit_in(addr),
    .sel_nxt(sel_nxt),
    .last_bit(last_bit),
    .timeout(timeout)
  );
  // grant, decode and release sequencing; a dropped request always wins over decode
  always_ff @(posedge clk)
    if (!rstn) begin
      state <= IDLE;
      bus_grant <= GRANT_NONE;
      slave_grant <= SLAVE_NONE;
      decode_error <= 1'b0;
      last_m2 <= 1'b1;
    end else begin
      decode_error <= 1'b0;
      case (state)
        IDLE:
          if (m1_request || m2_request) begin
            bus_grant <= pick_m2 ? GRANT_M2 : GRANT_M1;
            last_m2 <= pick_m2;
            state <= ADDR;
          end
        ADDR:
          if (!req) begin
            bus_grant <= GRANT_NONE;
            slave_grant <= SLAVE_NONE;
            state <= IDLE;
          end else if (last_bit) begin
            if (sel_nxt == '0) begin
              decode_error <= 1'b1;
              state <= HOLD;
            end else begin
              slave_grant <= {sel_nxt, 1'b1};
              state <= CONNECT;
            end
          end else if (timeout) begin
            decode_error <= 1'b1;
            state <= HOLD;
          end
        default:
          if (!req) begin
            bus_grant <= GRANT_NONE;
            slave_grant <= SLAVE_NONE;
            state <= IDLE;
          end
      endcase
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scoreboard bench driving per-cycle stimulus with hand-derived expected outputs
module tb_bus_arbiter;
  typedef struct {
    int due;
    string tag;
    logic [1:0] bg;
    logic [2:0] sg;
    logic de;
  } exp_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic m1_request = 1'b0;
  logic m2_request = 1'b0;
  logic m1_master_valid = 1'b0;
  logic m2_master_valid = 1'b0;
  logic m1_tx_address = 1'b0;
  logic m2_tx_address = 1'b0;
  logic [1:0] bus_grant;
  logic [2:0] slave_grant;
  logic m1_grant;
  logic m2_grant;
  logic decode_error;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q[$];
  bus_arbiter #(.ADDR_TIMEOUT(15)) dut (
    .clk(clk),
    .rstn(rstn),
    .m1_request(m1_request),
    .m2_request(m2_request),
    .m1_master_valid(m1_master_valid),
    .m2_master_valid(m2_master_valid),
    .m1_tx_address(m1_tx_address),
    .m2_tx_address(m2_tx_address),
    .bus_grant(bus_grant),
    .slave_grant(slave_grant),
    .m1_grant(m1_grant),
    .m2_grant(m2_grant),
    .decode_error(decode_error)
  );
  always #5 clk = ~clk;
  // cycle index advanced on every rising edge
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  // pop expectations that fall due this cycle and compare on the falling edge
  always @(negedge clk) begin : mon
    exp_t e;
    while (q.size() != 0 && q[0].due == cyc) begin
      e = q.pop_front();
      check(e.tag, {27'd0, bus_grant, slave_grant, decode_error}, {27'd0, e.bg, e.sg, e.de});
      check({e.tag, "/mgrant"}, {30'd0, m2_grant, m1_grant}, {30'd0, e.bg});
    end
  end
  task automatic drv(input string tag, input logic rn, input logic r1, input logic v1, input logic a1,
                     input logic r2, input logic v2, input logic a2,
                     input logic [1:0] bg, input logic [2:0] sg, input logic de);
    exp_t e;
    e.due = cyc + 1;
    e.tag = tag;
    e.bg = bg;
    e.sg = sg;
    e.de = de;
    q.push_back(e);
    rstn = rn;
    m1_request = r1;
    m1_master_valid = v1;
    m1_tx_address = a1;
    m2_request = r2;
    m2_master_valid = v2;
    m2_tx_address = a2;
    @(posedge clk);
    #1;
  endtask
  initial begin
    @(posedge clk);
    #1;
    drv("rst", 0, 0,0,0, 0,0,0, 2'b00, 3'b000, 0);
    drv("rst_hold", 0, 1,0,0, 1,0,0, 2'b00, 3'b000, 0);
    drv("t1_req", 1, 1,0,0, 0,0,0, 2'b01, 3'b000, 0);
    drv("t1_b1", 1, 1,1,1, 0,0,0, 2'b01, 3'b000, 0);
    drv("t1_b2", 1, 1,1,0, 0,0,0, 2'b01, 3'b101, 0);
    drv("t1_con", 1, 1,0,0, 0,0,0, 2'b01, 3'b101, 0);
    drv("t1_rel", 1, 0,0,0, 0,0,0, 2'b00, 3'b000, 0);
    drv("t2_rst", 0, 0,0,0, 0,0,0, 2'b00, 3'b000, 0);
    drv("t2_tie1", 1, 1,0,0, 1,0,0, 2'b01, 3'b000, 0);
    drv("t2_rel1", 1, 0,0,0, 1,0,0, 2'b00, 3'b000, 0);
    drv("t2_tie2", 1, 1,0,0, 1,0,0, 2'b10, 3'b000, 0);
    drv("t3_b1", 1, 0,1,0, 1,1,1, 2'b10, 3'b000, 0);
    drv("t3_gap1", 1, 1,1,1, 1,0,0, 2'b10, 3'b000, 0);
    drv("t3_gap2", 1, 0,1,1, 1,0,0, 2'b10, 3'b000, 0);
    drv("t3_gap3", 1, 1,1,1, 1,0,0, 2'b10, 3'b000, 0);
    drv("t3_b2", 1, 0,0,0, 1,1,1, 2'b10, 3'b111, 0);
    drv("t3_con", 1, 1,0,0, 1,0,0, 2'b10, 3'b111, 0);
    drv("t3_rel", 1, 0,0,0, 0,0,0, 2'b00, 3'b000, 0);
    drv("t4_req", 1, 1,0,0, 0,0,0, 2'b01, 3'b000, 0);
    drv("t4_b1", 1, 1,1,0, 0,0,0, 2'b01, 3'b000, 0);
    drv("t4_b2", 1, 1,1,0, 1,0,0, 2'b01, 3'b000, 1);
    drv("t4_hold1", 1, 1,0,0, 1,0,0, 2'b01, 3'b000, 0);
    drv("t4_hold2", 1, 1,1,1, 1,1,1, 2'b01, 3'b000, 0);
    drv("t4_rel", 1, 0,0,0, 1,0,0, 2'b00, 3'b000, 0);
    drv("t4_m2", 1, 0,0,0, 1,0,0, 2'b10, 3'b000, 0);
    drv("t4_m2rel", 1, 0,0,0, 0,0,0, 2'b00, 3'b000, 0);
    drv("t5_req", 1, 1,0,0, 0,0,0, 2'b01, 3'b000, 0);
    for (int i = 0; i < 15; i++)
      drv($sformatf("t5_wait%0d", i), 1, 1,0,0, 0,0,0, 2'b01, 3'b000, i == 14);
    drv("t5_hold", 1, 1,0,0, 0,0,0, 2'b01, 3'b000, 0);
    drv("t5_rel", 1, 0,0,0, 0,0,0, 2'b00, 3'b000, 0);
    drv("t6_req", 1, 1,0,0, 0,0,0, 2'b01, 3'b000, 0);
    drv("t6_b1", 1, 1,1,0, 0,0,0, 2'b01, 3'b000, 0);
    drv("t6_b2", 1, 1,1,1, 1,0,0, 2'b01, 3'b011, 0);
    drv("t6_rst", 0, 1,0,0, 1,0,0, 2'b00, 3'b000, 0);
    drv("t6_rst2", 0, 0,0,0, 1,0,0, 2'b00, 3'b000, 0);
    drv("t6_m2", 1, 0,0,0, 1,0,0, 2'b10, 3'b000, 0);
    drv("t6_rel", 1, 0,0,0, 0,0,0, 2'b00, 3'b000, 0);
    repeat (3) @(negedge clk);
    check("drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
endmodule
